// File: rtl/edu_token_scheduler.sv
// edu_token_scheduler: latches a token-row occupancy vector and drains the
// occupied rows lowest-index-first over a valid/ready handshake, pulsing
// done for one cycle after the last row has been accepted.
module edu_token_scheduler #(
    parameter int NUM_AQROW    = 4,
    parameter int NUM_AQCOL    = 4,
    parameter int TKROWADDR_BW = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [NUM_AQROW+NUM_AQCOL-2:0]    load_rows,
    input  logic                              flush,
    output logic                              tk_valid,
    input  logic                              tk_ready,
    output logic [TKROWADDR_BW-1:0]           tk_row,
    output logic [NUM_AQROW+NUM_AQCOL-2:0]    tk_onehot,
    output logic                              done,
    output logic                              busy,
    output logic [TKROWADDR_BW:0]             tk_cnt
);

    localparam int W     = NUM_AQROW + NUM_AQCOL - 1;
    localparam int CNT_W = TKROWADDR_BW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         pending_q, pending_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [TKROWADDR_BW-1:0] enc_row;
    logic [W-1:0]            enc_onehot;
    logic                    enc_found;
    logic [W-1:0]            pending_cleared;

    // Lowest-index priority encode of the registered pending set only,
    // so tk_row has no combinational dependency on tk_ready.
    always_comb begin
        enc_row    = '0;
        enc_onehot = '0;
        enc_found  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!enc_found && pending_q[i]) begin
                enc_found     = 1'b1;
                enc_row       = TKROWADDR_BW'(i);
                enc_onehot[i] = 1'b1;
            end
        end
    end

    assign pending_cleared = pending_q & ~enc_onehot;

    // Next-state logic: flush wins over load and handshake, and a
    // handshake coinciding with flush is neither cleared nor counted.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (flush) begin
            state_d   = IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        pending_d = load_rows;
                        cnt_d     = '0;
                        state_d   = (load_rows != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (tk_ready) begin
                        pending_d = pending_cleared;
                        cnt_d     = cnt_q + CNT_W'(1);
                        if (pending_cleared == '0) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d   = IDLE;
                    pending_d = '0;
                end
            endcase
        end
    end

    // State, pending set and issue counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign tk_valid   = (state_q == ISSUE);
    assign tk_row     = (state_q == ISSUE) ? enc_row : '0;
    assign tk_onehot  = (state_q == ISSUE) ? enc_onehot : '0;
    assign done       = (state_q == DONE);
    assign busy       = (state_q == ISSUE) || (state_q == DONE);
    assign tk_cnt     = cnt_q;

endmodule

// File: tb/tb_edu_token_scheduler.sv
// Testbench for edu_token_scheduler: table-driven schedules, hand-written
// corner sequences and randomized drains checked against a queue model.
module tb_edu_token_scheduler;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_rows;
    logic         flush;
    logic         tk_valid;
    logic         tk_ready;
    logic [2:0]   tk_row;
    logic [W-1:0] tk_onehot;
    logic         done;
    logic         busy;
    logic [3:0]   tk_cnt;

    int nvec = 0;
    int nerr = 0;

    edu_token_scheduler #(
        .NUM_AQROW   (4),
        .NUM_AQCOL   (4),
        .TKROWADDR_BW(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_rows (load_rows),
        .flush     (flush),
        .tk_valid  (tk_valid),
        .tk_ready  (tk_ready),
        .tk_row    (tk_row),
        .tk_onehot (tk_onehot),
        .done      (done),
        .busy      (busy),
        .tk_cnt    (tk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset_values(input string tag);
        chk({tag, "_load_ready"}, load_ready, 1);
        chk({tag, "_tk_valid"}, tk_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tk_cnt"}, tk_cnt, 0);
        chk({tag, "_tk_row"}, tk_row, 0);
        chk({tag, "_tk_onehot"}, tk_onehot, 0);
    endtask

    // Load a vector and drain it. The model is simply the ascending list of
    // set bit indices; each accepted handshake pops its head. ready_pct is the
    // probability (percent) of tk_ready being high in any ISSUE cycle.
    task automatic drain(input logic [W-1:0] rows, input int ready_pct,
                         output int issued, output int last_row);
        int q[$];
        int cnt;
        int budget;
        bit rdy;
        for (int i = 0; i < W; i++) if (rows[i]) q.push_back(i);
        cnt      = 0;
        last_row = -1;
        chk("drain_load_ready", load_ready, 1);
        load_valid = 1'b1;
        load_rows  = rows;
        tk_ready   = 1'b0;
        step();
        load_valid = 1'b0;
        load_rows  = $urandom;
        budget     = 0;
        while (1) begin
            if (budget > 300) begin
                chk("drain_timeout", 1, 0);
                break;
            end
            budget++;
            if (q.size() == 0) begin
                chk("drain_done", done, 1);
                chk("drain_done_tk_valid", tk_valid, 0);
                chk("drain_done_busy", busy, 1);
                chk("drain_done_cnt", tk_cnt, cnt);
                tk_ready = 1'b0;
                step();
                chk("drain_after_done", done, 0);
                chk("drain_after_ready", load_ready, 1);
                chk("drain_after_cnt", tk_cnt, cnt);
                break;
            end
            chk("drain_tk_valid", tk_valid, 1);
            chk("drain_tk_row", tk_row, q[0]);
            chk("drain_tk_onehot", tk_onehot, 32'd1 << q[0]);
            chk("drain_done_low", done, 0);
            chk("drain_cnt", tk_cnt, cnt);
            chk("drain_load_ready_low", load_ready, 0);
            rdy = ($urandom_range(99) < ready_pct);
            tk_ready = rdy;
            step();
            if (rdy) begin
                last_row = q.pop_front();
                cnt++;
            end
        end
        tk_ready = 1'b0;
        issued   = cnt;
    endtask

    typedef struct {
        logic [W-1:0] rows;
        int           exp_cnt;
        int           exp_last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, last;
        tbl[0] = '{7'b0100101, 3, 5};
        tbl[1] = '{7'b0000000, 0, -1};
        tbl[2] = '{7'b1111111, 7, 6};
        tbl[3] = '{7'b1000000, 1, 6};
        tbl[4] = '{7'b0000001, 1, 0};
        tbl[5] = '{7'b1010010, 3, 6};

        rst        = 1'b1;
        load_valid = 1'b0;
        load_rows  = '0;
        flush      = 1'b0;
        tk_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk_idle_reset_values("reset");

        // Table-driven schedules with tk_ready tied high.
        for (int k = 0; k < 6; k++) begin
            drain(tbl[k].rows, 100, n, last);
            chk("tbl_cnt", n, tbl[k].exp_cnt);
            chk("tbl_last", last, tbl[k].exp_last);
            chk("tbl_tk_cnt", tk_cnt, tbl[k].exp_cnt);
        end

        // Single row with backpressure: held stable for 3 stalled cycles.
        load_valid = 1'b1; load_rows = 7'b1000000; tk_ready = 1'b0;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", tk_valid, 1);
            chk("stall_row", tk_row, 6);
            chk("stall_cnt", tk_cnt, 0);
            step();
        end
        chk("stall_row4", tk_row, 6);
        tk_ready = 1'b1;
        step();
        tk_ready = 1'b0;
        chk("stall_done", done, 1);
        chk("stall_tk_cnt", tk_cnt, 1);
        step();
        chk("stall_idle", load_ready, 1);

        // Flush after two handshakes: no done, count holds, new load works.
        load_valid = 1'b1; load_rows = 7'b1111111;
        step();
        load_valid = 1'b0; tk_ready = 1'b1;
        step();
        step();
        chk("flush_pre_row", tk_row, 2);
        flush = 1'b1;
        step();
        flush = 1'b0; tk_ready = 1'b0;
        chk("flush_idle", load_ready, 1);
        chk("flush_valid", tk_valid, 0);
        chk("flush_done", done, 0);
        chk("flush_busy", busy, 0);
        chk("flush_cnt", tk_cnt, 2);
        step();
        chk("flush_done2", done, 0);
        chk("flush_cnt2", tk_cnt, 2);
        drain(7'b0000010, 100, n, last);
        chk("flush_reload_last", last, 1);

        // Flush coinciding with a load in IDLE: load is dropped.
        load_valid = 1'b1; load_rows = 7'b0000100; flush = 1'b1;
        step();
        load_valid = 1'b0; flush = 1'b0;
        chk("flush_load_idle", load_ready, 1);
        chk("flush_load_valid", tk_valid, 0);

        // load_valid during ISSUE is ignored.
        load_valid = 1'b1; load_rows = 7'b0001100;
        step();
        load_rows = 7'b0000001; tk_ready = 1'b1;
        chk("ign_row0", tk_row, 2);
        step();
        chk("ign_row1", tk_row, 3);
        chk("ign_valid1", tk_valid, 1);
        step();
        load_valid = 1'b0; tk_ready = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_cnt", tk_cnt, 2);
        step();
        chk("ign_idle", load_ready, 1);
        chk("ign_no_reissue", tk_valid, 0);

        // Reset in the middle of ISSUE.
        load_valid = 1'b1; load_rows = 7'b1111111;
        step();
        load_valid = 1'b0; tk_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; tk_ready = 1'b0;
        chk_idle_reset_values("midrst");

        // Randomized drains with random backpressure.
        for (int r = 0; r < 40; r++) begin
            logic [W-1:0] rv;
            int pc;
            rv = W'($urandom);
            pc = 0;
            for (int i = 0; i < W; i++) if (rv[i]) pc++;
            drain(rv, 30 + $urandom_range(70), n, last);
            chk("rnd_cnt", n, pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edu_token_scheduler.md
Name: edu_token_scheduler

Overview:
Sequencer for EDU token setup. It latches one row-occupancy vector of NUM_AQROW+NUM_AQCOL-1 bits, then issues the occupied token rows one at a time over a valid/ready handshake.
- Order: lowest index first.
- Each issued row's bit is cleared from the pending set.
- A done pulse marks the last issue.
It sits between the row-occupancy producer and the token-row consumer, and replaces one-shot combinational first-row selection with a multi-cycle scheduled drain.

Parameters:
NUM_AQROW, 4, number of AQ rows
NUM_AQCOL, 4, number of AQ columns
TKROWADDR_BW, 3, token row index width; must satisfy 2^TKROWADDR_BW >= NUM_AQROW+NUM_AQCOL-1
(Below, W = NUM_AQROW+NUM_AQCOL-1; default W = 7.)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous reset, active-high
load_valid  input  1  new occupancy vector offered
load_ready  output  1  high only in IDLE; load accepted when load_valid & load_ready
load_rows  input  W  occupancy vector, bit i = token row i occupied
flush  input  1  abort current schedule
tk_valid  output  1  token row offered downstream
tk_ready  input  1  downstream accepts token row
tk_row  output  TKROWADDR_BW  index of lowest set pending bit
tk_onehot  output  W  one-hot of tk_row; zero when tk_valid=0
done  output  1  one-cycle pulse after the schedule completes
busy  output  1  high in ISSUE and DONE
tk_cnt  output  TKROWADDR_BW+1  rows issued in the current schedule

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; pending=0; tk_cnt=0.
  - All outputs 0 except load_ready=1.
  - rst overrides every other input.
- State machine: IDLE, ISSUE, DONE.
- IDLE:
  - load_ready=1; tk_valid=0.
  - On load: pending<=load_rows and tk_cnt<=0.
  - Next state is ISSUE if load_rows!=0, otherwise DONE.
- ISSUE:
  - tk_valid=1.
  - tk_row/tk_onehot are a priority encode (lowest index) of the registered pending. This is combinational from registers only; there is no path from tk_ready to tk_row.
  - On tk_valid & tk_ready: clear the tk_onehot bit in pending and tk_cnt<=tk_cnt+1.
  - If the cleared bit was the last set bit, go to DONE; otherwise stay in ISSUE.
  - tk_ready low: hold pending, tk_row and tk_cnt stable; tk_valid stays high with no retraction.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - tk_cnt holds its final value until the next load or rst.
- Timing:
  - Load accepted at edge t gives tk_valid=1 in cycle t+1.
  - Throughput is one token per cycle while tk_ready=1.
  - N occupied rows with tk_ready tied high: done is asserted in cycle t+N+1.
  - Empty vector: done in cycle t+1, tk_valid never asserted, tk_cnt=0.
- flush:
  - In any state, next state is IDLE, pending<=0, and no done pulse.
  - tk_cnt holds its value.
  - flush has priority over a same-cycle load and handshake. A handshake coinciding with flush is not counted, and the consumer must discard it.
- load_valid outside IDLE is ignored (load_ready=0). There is no queuing.
- Bits of load_rows at index >= W do not exist. tk_row never exceeds W-1.

Test Plan:
- rst then idle -> load_ready=1; tk_valid=0; done=0; tk_cnt=0; busy=0.
- Load 7'b0100101, tk_ready=1 -> tk_row 0,2,5 on consecutive cycles; tk_onehot 0000001,0000100,0100000; done one cycle later; tk_cnt=3.
- Load 7'b1000000, tk_ready low 3 cycles then high -> tk_valid held with tk_row=6 for 4 cycles; one handshake; done next cycle; tk_cnt=1.
- Load 7'b0 -> done in cycle after load; tk_valid never high; back in IDLE the cycle after.
- Load 7'b1111111, flush after 2 handshakes -> IDLE next cycle; no done; tk_cnt=2; new load 7'b0000010 issues tk_row=1.
- load_valid pulsed during ISSUE with 7'b0000001 while draining 7'b0001100 -> ignored; only rows 2,3 issued; assert rst mid-ISSUE -> outputs at reset values next cycle.
